// File: rtl/chien_pkg.sv
// chien_pkg: shared constants, types and GF(2^m) helpers for the Chien search engine.
//   PARAM_M          field degree (element width)
//   PARAM_POLY       primitive polynomial including the x^m term
//   PARAM_T          maximum locator degree (PARAM_T+1 coefficient lanes)
//   PARAM_N          number of positions evaluated (<= 2^PARAM_M-1)
//   PARAM_FIFO_DEPTH root FIFO entries (power of two, >= 2)
package chien_pkg;

  localparam int PARAM_M          = 9;
  localparam int PARAM_POLY       = 'h211;
  localparam int PARAM_T          = 8;
  localparam int PARAM_N          = 511;
  localparam int PARAM_FIFO_DEPTH = 4;

  localparam int LANES = PARAM_T + 1;
  localparam int IDX_W = $clog2(PARAM_T + 1);
  localparam int POS_W = $clog2(PARAM_N);
  localparam int CNT_W = $clog2(PARAM_N + 1);

  typedef logic [PARAM_M-1:0] gf_elem_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } chien_state_e;

  // Multiply by alpha: shift left and fold the x^m term back via the low polynomial bits.
  function automatic gf_elem_t gf_xtime(gf_elem_t a);
    gf_elem_t shifted;
    shifted = {a[PARAM_M-2:0], 1'b0};
    if (a[PARAM_M-1]) begin
      return shifted ^ gf_elem_t'(PARAM_POLY);
    end else begin
      return shifted;
    end
  endfunction

  // Multiply by alpha^k; k is a constant at every call site, so this unrolls to an XOR network.
  function automatic gf_elem_t gf_mul_const(gf_elem_t a, int unsigned k);
    gf_elem_t acc;
    acc = a;
    for (int unsigned i = 0; i < k; i++) begin
      acc = gf_xtime(acc);
    end
    return acc;
  endfunction

  // alpha^k as an elaboration-time constant.
  function automatic gf_elem_t alpha_pow(int unsigned k);
    return gf_mul_const(gf_elem_t'(1), k % ((2 ** PARAM_M) - 1));
  endfunction

endpackage

// File: rtl/chien_search_engine_root_fifo.sv
// chien_root_fifo: synchronous FIFO holding root positions, registered full/empty flags.
//   clk, rst   clock, asynchronous active-high reset (FIFO empties)
//   push       write push_data (taken when not full, or when a pop frees a slot)
//   pop        remove head (ignored when empty)
//   full/empty occupancy flags
//   head       current head entry
module chien_root_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int FCNT_W = $clog2(DEPTH + 1);
  localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);
  localparam logic [FCNT_W-1:0] FCNT_FULL = FCNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

  logic [WIDTH-1:0]  mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [FCNT_W-1:0] cnt_r;
  logic [FCNT_W-1:0] cnt_next_s;
  logic              full_r;
  logic              empty_r;
  logic              do_push_s;
  logic              do_pop_s;

  // Qualify requests; a pop in the same cycle makes room for a push into a full FIFO.
  always_comb begin
    do_pop_s  = pop & ~empty_r;
    do_push_s = push & (~full_r | do_pop_s);
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_next_s = cnt_r + FCNT_ONE;
      2'b01:   cnt_next_s = cnt_r - FCNT_ONE;
      default: cnt_next_s = cnt_r;
    endcase
  end

  // Storage, pointers (wrap naturally: DEPTH is a power of two) and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      cnt_r   <= cnt_next_s;
      full_r  <= (cnt_next_s == FCNT_FULL);
      empty_r <= (cnt_next_s == '0);
    end
  end

  assign full  = full_r;
  assign empty = empty_r;
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/chien_search_engine.sv
// chien_search_engine: autonomous full Chien search over GF(2^PARAM_M), one position per cycle.
// Evaluates sigma(alpha^i), i = 0..PARAM_N-1, and streams roots i through a ready/valid FIFO.
//   coef_we/coef_idx/coef_data  load sigma_j while IDLE (idx > PARAM_T ignored)
//   degree, start               deg(sigma) latched on an accepted start pulse
//   busy, done                  search in progress / one-cycle end pulse
//   err_count, fail             roots found and (count != degree), valid from done
//   root_valid/root_ready/root_pos  root stream
// Optional: define CHIEN_EARLY_TERM_EN to end the search once err_count reaches the
// latched (non-zero) degree.
module chien_search_engine
  import chien_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             coef_we,
  input  logic [IDX_W-1:0] coef_idx,
  input  logic [PARAM_M-1:0] coef_data,
  input  logic [IDX_W-1:0] degree,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic             fail,
  output logic             root_valid,
  input  logic             root_ready,
  output logic [POS_W-1:0] root_pos
);

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(PARAM_N - 1);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  chien_state_e     state_r;
  gf_elem_t         coef_r [LANES];
  gf_elem_t         lane_r [LANES];
  logic [POS_W-1:0] cntr_r;
  logic [IDX_W-1:0] degree_r;
  logic [CNT_W-1:0] err_count_r;
  logic             busy_r;
  logic             done_r;
  logic             fail_r;

  gf_elem_t         sum_s;
  logic             pop_s;
  logic             stall_s;
  logic             push_s;
  logic             last_s;
  logic             early_s;
  logic [CNT_W-1:0] err_next_s;
  logic [CNT_W-1:0] degree_ext_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;

  assign pop_s        = ~fifo_empty_s & root_ready;
  assign degree_ext_s = CNT_W'(degree_r);

  // Evaluate sigma(alpha^cntr) and decide push / stall / exit for this cycle.
  always_comb begin
    sum_s = '0;
    for (int j = 0; j < LANES; j++) begin
      sum_s = sum_s ^ lane_r[j];
    end
    stall_s    = 1'b0;
    push_s     = 1'b0;
    last_s     = 1'b0;
    early_s    = 1'b0;
    err_next_s = err_count_r;
    if (state_r == SEARCH) begin
      // Only a root that cannot enter the FIFO stalls; a pop this cycle frees a slot.
      stall_s = (sum_s == '0) & fifo_full_s & ~pop_s;
      push_s  = (sum_s == '0) & ~stall_s;
      if (push_s) begin
        err_next_s = err_count_r + CNT_ONE;
      end else begin
        err_next_s = err_count_r;
      end
      last_s = ~stall_s & (cntr_r == LAST_POS);
`ifdef CHIEN_EARLY_TERM_EN
      early_s = push_s & (err_next_s == degree_ext_s) & (degree_r != '0);
`else
      early_s = 1'b0;
`endif
    end else begin
      stall_s = 1'b0;
    end
  end

  // Coefficient staging registers, writable only while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < LANES; j++) begin
        coef_r[j] <= '0;
      end
    end else if ((state_r == IDLE) && coef_we && (int'(coef_idx) <= PARAM_T)) begin
      coef_r[coef_idx] <= coef_data;
    end
  end

  // Control FSM, lane registers, position counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      for (int j = 0; j < LANES; j++) begin
        lane_r[j] <= '0;
      end
      cntr_r      <= '0;
      degree_r    <= '0;
      err_count_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      fail_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r     <= SEARCH;
            busy_r      <= 1'b1;
            lane_r      <= coef_r;
            cntr_r      <= '0;
            degree_r    <= degree;
            err_count_r <= '0;
            fail_r      <= 1'b0;
          end
        end
        SEARCH: begin
          if (!stall_s) begin
            // Lane j carries sigma_j * alpha^(j*cntr); r_0 is constant.
            for (int j = 1; j < LANES; j++) begin
              lane_r[j] <= gf_mul_const(lane_r[j], j);
            end
            cntr_r      <= cntr_r + POS_ONE;
            err_count_r <= err_next_s;
            if (last_s || early_s) begin
              state_r <= DONE;
              done_r  <= 1'b1;
              fail_r  <= (err_next_s != degree_ext_s);
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  chien_root_fifo #(
    .WIDTH (POS_W),
    .DEPTH (PARAM_FIFO_DEPTH)
  ) u_root_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (cntr_r),
    .pop       (pop_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .head      (root_pos)
  );

  assign busy       = busy_r;
  assign done       = done_r;
  assign err_count  = err_count_r;
  assign fail       = fail_r;
  assign root_valid = ~fifo_empty_s;

endmodule

// File: doc/chien_search_engine.md
Name: chien_search_engine

Overview:
- Full Chien search for BCH/HQC-style decoders: evaluates error-locator polynomial sigma(x) of degree <= PARAM_T at alpha^i for i = 0..PARAM_N-1 in GF(2^PARAM_M), one position per cycle.
- Successor to the 4-lane, host-stepped Chien multiplier accelerator. Lane count, field and code length are parametrised; the block runs autonomously and streams root positions through an internal FIFO with ready/valid backpressure.
- Sits behind the PQ accelerator host interface, between the Berlekamp-Massey stage and error correction.

Parameters:
- PARAM_M, 9, field degree m; element width.
- PARAM_POLY, 'h211, primitive polynomial including the x^m term (x^9+x^4+1).
- PARAM_T, 8, maximum locator degree; number of coefficient lanes is PARAM_T+1.
- PARAM_N, 511, number of positions evaluated; must be <= 2^PARAM_M-1.
- PARAM_FIFO_DEPTH, 4, root FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- coef_we  in  1  write sigma coefficient (accepted only in IDLE)
- coef_idx  in  $clog2(PARAM_T+1)  coefficient index j; values > PARAM_T are ignored
- coef_data  in  PARAM_M  sigma_j
- degree  in  $clog2(PARAM_T+1)  deg(sigma), sampled at start
- start  in  1  single-cycle start pulse
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at end of search
- err_count  out  $clog2(PARAM_N+1)  roots found; valid from done until next start
- fail  out  1  err_count != sampled degree; valid with err_count
- root_valid  out  1  FIFO head valid
- root_ready  in  1  consumer accepts head
- root_pos  out  $clog2(PARAM_N)  exponent i such that sigma(alpha^i) = 0

Behaviour:
- Reset: all coefficient and lane registers 0; state IDLE; busy, done, fail, root_valid, err_count all 0; FIFO empty. Reset mid-search aborts immediately and discards FIFO contents.
- FSM states: IDLE -> (start) SEARCH -> (position index = PARAM_N-1 evaluated) DONE -> IDLE. DONE lasts one cycle and asserts done.
- start is ignored while busy. coef_we is ignored outside IDLE.
- Lane registers: on accepted start, r_j <= sigma_j and cntr <= 0, and degree is latched.
- Each non-stalled SEARCH cycle:
  - sum = XOR over j = 0..PARAM_T of r_j, which equals sigma(alpha^cntr).
  - If sum == 0: push cntr into the FIFO and increment err_count.
  - Update r_j <= r_j * alpha^j for j >= 1 (constant GF multiply, combinational); r_0 holds.
  - cntr increments.
- Stall: if the FIFO is full and sum == 0, nothing advances (lanes, cntr and err_count hold). Evaluation resumes the cycle after space frees. A full FIFO with sum != 0 does not stall.
- Latency: with no stalls, done asserts PARAM_N+1 cycles after start. A root is pushed in its evaluation cycle; root_valid rises the next cycle.
- FIFO handshake: pop on root_valid & root_ready. Simultaneous push and pop when full is allowed and counts as not full for the push.
- Entries remain poppable after done and in IDLE. A new start does not flush the FIFO.
- All-zero sigma: every position is a root and the FIFO stalls as needed; err_count = PARAM_N and fail = 1 unless PARAM_N equals the latched degree.
- err_count and fail are cleared on accepted start.

Optional Feature:
- Macro: CHIEN_EARLY_TERM_EN.
- Defined: SEARCH exits to DONE in the cycle a push makes err_count equal the latched degree (and degree > 0). fail = 0 in that case. done latency becomes (index of last root)+2.
- Undefined: all PARAM_N positions are always evaluated.

Decomposition:
- Package chien_pkg:
  - state enum (IDLE, SEARCH, DONE);
  - function gf_mul_const(a, k) implementing constant multiply by alpha^k modulo PARAM_POLY;
  - function alpha_pow(k) for elaboration-time constants.
- Sub-module chien_root_fifo: synchronous FIFO with full/empty flags, parameterised on width and depth.

Test Plan:
- sigma_0 = 1, sigma_1 = 1, degree = 1, root_ready = 1 -> single root_pos = 0; err_count = 1, fail = 0; done 512 cycles after start.
- sigma_0 = 1, sigma_1 = 8 (alpha^3), degree = 1 -> single root_pos = 508; err_count = 1.
- sigma = (1+x)(1+alpha^3 x), i.e. sigma_0 = 1, sigma_1 = 9, sigma_2 = 8, degree = 2, root_ready held 0 -> roots 0 and 508 buffered without loss; releasing root_ready yields 0 then 508 in order.
- All-zero sigma with PARAM_FIFO_DEPTH = 4 and root_ready toggling every other cycle -> 511 roots 0..510 in order, no drops; err_count = 511, fail = 1.
- start and coef_we pulsed mid-search -> ignored; results identical to an undisturbed run. rst asserted at cycle 100 -> busy = 0 and root_valid = 0 immediately; a fresh run is correct afterwards.
- With CHIEN_EARLY_TERM_EN defined, second scenario's polynomial -> done at cycle 510 after start instead of 512; fail = 0.
